// File: rtl/pool_result_drain.sv
// pool_result_drain: de-skews column-staggered pooling results into a row
// FIFO and streams each row out as col/beat_cols valid/ready beats.
//
// Ports:
//   clk, nrst      clock; synchronous active-high reset
//   pool_data[j]   column j result, valid when pool_done[j]
//   pool_done[j]   column j strobe, j cycles after column 0 of the same row
//   out_ready      downstream accepts the current beat
//   clear_ovf      clears the sticky overflow flag
//   out_valid      a beat is presented
//   out_data       beat payload, lowest column in the LSBs
//   out_last       final beat of the row
//   out_row_idx    16-bit index of the row being emitted
//   overflow       sticky: a row was dropped because the FIFO was full
//   busy           a row is in flight or buffered

module pool_result_drain #(
  parameter int data_width = 16,
  parameter int col        = 32,
  parameter int beat_cols  = 8,
  parameter int fifo_depth = 4
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [data_width-1:0]           pool_data [col],
  input  logic                            pool_done [col],
  input  logic                            out_ready,
  input  logic                            clear_ovf,
  output logic                            out_valid,
  output logic [beat_cols*data_width-1:0] out_data,
  output logic                            out_last,
  output logic [15:0]                     out_row_idx,
  output logic                            overflow,
  output logic                            busy
);

  localparam int beats  = col / beat_cols;
  localparam int ptr_w  = $clog2(fifo_depth);
  localparam int cnt_w  = $clog2(fifo_depth + 1);
  localparam int beat_w = (beats > 1) ? $clog2(beats) : 1;
  localparam int row_w  = col * data_width;
  localparam int bw     = beat_cols * data_width;

  typedef logic [ptr_w-1:0] ptr_t;
  typedef logic [cnt_w-1:0] cnt_t;

  localparam logic [cnt_w:0]    depth_c = (cnt_w+1)'(fifo_depth);
  localparam logic [beat_w-1:0] last_c  = beat_w'(beats - 1);

  logic [row_w-1:0] mem [fifo_depth];
  logic [row_w-1:0] rd_row;

  ptr_t              alloc_ptr;
  ptr_t              rd_ptr;
  cnt_t              committed;
  cnt_t              inflight;
  logic [beat_w-1:0] beat;

  // Slot and drop bit for a row travel down one stage per column, so
  // column j sees its row's slot exactly when pool_done[j] arrives.
  ptr_t pipe_slot [1:col-1];
  logic pipe_drop [1:col-1];

  ptr_t col_slot [col];
  logic col_drop [col];

  logic [cnt_w:0] occupancy;
  logic           admit;
  logic           drop;
  logic           commit;
  logic           last_beat;
  logic           fire;
  logic           pop;

  // Occupancy counts rows still in flight, so a row is only admitted
  // when every in-flight row is already guaranteed a slot.
  assign occupancy = {1'b0, committed} + {1'b0, inflight};
  assign admit     = pool_done[0] && (occupancy < depth_c);
  assign drop      = pool_done[0] && !admit;

  always_comb begin
    col_slot[0] = alloc_ptr;
    col_drop[0] = !admit;
    for (int j = 1; j < col; j++) begin
      col_slot[j] = pipe_slot[j];
      col_drop[j] = pipe_drop[j];
    end
  end

  assign commit    = pool_done[col-1] && !col_drop[col-1];
  assign last_beat = (beat == last_c);
  assign out_valid = (committed != '0);
  assign fire      = out_valid && out_ready;
  assign pop       = fire && last_beat;
  assign out_last  = out_valid && last_beat;
  assign busy      = (committed != '0) || (inflight != '0);

  assign rd_row = mem[rd_ptr];

  always_comb begin
    out_data = '0;
    for (int b = 0; b < beats; b++) begin
      if (out_valid && (beat == beat_w'(b))) begin
        out_data = rd_row[b*bw +: bw];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int j = 0; j < col; j++) begin
        if (pool_done[j] && !col_drop[j]) begin
          mem[col_slot[j]][j*data_width +: data_width] <= pool_data[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      alloc_ptr   <= '0;
      rd_ptr      <= '0;
      committed   <= '0;
      inflight    <= '0;
      beat        <= '0;
      out_row_idx <= '0;
      overflow    <= 1'b0;
      // Drop bits come out of reset set, so late strobes of a row that
      // was in flight at reset are ignored rather than committed.
      for (int j = 1; j < col; j++) begin
        pipe_slot[j] <= '0;
        pipe_drop[j] <= 1'b1;
      end
    end else begin
      pipe_slot[1] <= col_slot[0];
      pipe_drop[1] <= col_drop[0];
      for (int j = 2; j < col; j++) begin
        pipe_slot[j] <= pipe_slot[j-1];
        pipe_drop[j] <= pipe_drop[j-1];
      end

      if (admit) begin
        alloc_ptr <= alloc_ptr + 1'b1;
      end

      inflight  <= inflight + cnt_t'(admit) - cnt_t'(commit);
      committed <= committed + cnt_t'(commit) - cnt_t'(pop);

      if (fire) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end

      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        out_row_idx <= out_row_idx + 16'd1;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
